// File: rtl/execute_stage.sv
// Execute stage of the RV32IM pipeline: ALU, branch/jump resolution and an
// iterative shift-add multiplier feeding the execute->memory latch.
module execute_stage #(
    parameter int WORD_W      = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic [WORD_W-1:0] pc,
    input  logic [3:0]        alu_op,
    input  logic              mult,
    input  logic              mult_half,
    input  logic              mult_signed_a,
    input  logic              mult_signed_b,
    input  logic [4:0]        rd,
    input  logic              dread,
    input  logic [1:0]        dwrite,
    input  logic              halt,
    input  logic [WORD_W-1:0] immediate,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic              alu_src1,
    input  logic              alu_src2,
    input  logic [1:0]        reg_wr_src,
    input  logic              branch_pol,
    input  logic [1:0]        pc_ctrl,
    output logic              ex_stall,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_result,
    output logic [WORD_W-1:0] out_wdata,
    output logic [4:0]        out_rd,
    output logic              out_dread,
    output logic [1:0]        out_dwrite,
    output logic [1:0]        out_reg_wr_src,
    output logic              out_halt,
    output logic [WORD_W-1:0] out_pc_plus4
);
    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSll  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluSlt  = 4'd8;
    localparam logic [3:0] AluSltu = 4'd9;

    localparam int CntW = $clog2(MULT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(MULT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mult_state_e;

    mult_state_e         state_q, state_d;
    logic [2*WORD_W-1:0] mcand_q, acc_q, product;
    logic [WORD_W-1:0]   mplier_q;
    logic [CntW-1:0]     cnt_q;
    logic                neg_q;

    logic [WORD_W-1:0] op_a, op_b, alu_result, a_abs, b_abs, mult_result;
    logic [WORD_W-1:0] jalr_sum;
    logic [4:0]        shamt;
    logic              zero, mult_start, mult_done, lat_valid, redir_ok;

    always_comb begin
        op_a  = alu_src1 ? pc : rdat1;
        op_b  = alu_src2 ? immediate : rdat2;
        shamt = op_b[4:0];
        case (alu_op)
            AluAdd:  alu_result = op_a + op_b;
            AluSub:  alu_result = op_a - op_b;
            AluAnd:  alu_result = op_a & op_b;
            AluOr:   alu_result = op_a | op_b;
            AluXor:  alu_result = op_a ^ op_b;
            AluSll:  alu_result = op_a << shamt;
            AluSrl:  alu_result = op_a >> shamt;
            AluSra:  alu_result = WORD_W'($signed(op_a) >>> shamt);
            AluSlt:  alu_result = {{(WORD_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            AluSltu: alu_result = {{(WORD_W-1){1'b0}}, op_a < op_b};
            default: alu_result = '0;
        endcase
        zero = (alu_result == '0);
    end

    // Redirect only fires while the instruction is actually advancing.
    always_comb begin
        redir_ok    = in_valid & ~flush & ~mem_stall;
        jalr_sum    = rdat1 + immediate;
        redirect    = 1'b0;
        redirect_pc = pc + immediate;
        case (pc_ctrl)
            2'd1: redirect = redir_ok & (zero ^ branch_pol);
            2'd2: redirect = redir_ok;
            2'd3: begin
                redirect    = redir_ok;
                redirect_pc = {jalr_sum[WORD_W-1:1], 1'b0};
            end
            default: redirect = 1'b0;
        endcase
    end

    assign mult_start = in_valid & mult & ~flush;
    assign mult_done  = (state_q == StDone);
    assign a_abs = (mult_signed_a & rdat1[WORD_W-1]) ? -rdat1 : rdat1;
    assign b_abs = (mult_signed_b & rdat2[WORD_W-1]) ? -rdat2 : rdat2;
    assign product     = neg_q ? -acc_q : acc_q;
    assign mult_result = mult_half ? product[2*WORD_W-1:WORD_W] : product[WORD_W-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mult_start) state_d = StBusy;
            StBusy:  if (cnt_q == CntLast) state_d = StDone;
            StDone:  if (!mem_stall) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    assign ex_stall = mem_stall | (in_valid & mult & (state_q == StIdle)) |
                      (state_q == StBusy) | (mult_done & mem_stall);

    assign lat_valid = in_valid & ~flush & (~mult | mult_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            mcand_q        <= '0;
            mplier_q       <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            neg_q          <= 1'b0;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_wdata      <= '0;
            out_rd         <= '0;
            out_dread      <= 1'b0;
            out_dwrite     <= '0;
            out_reg_wr_src <= '0;
            out_halt       <= 1'b0;
            out_pc_plus4   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && mult_start) begin
                mcand_q  <= {{WORD_W{1'b0}}, a_abs};
                mplier_q <= b_abs;
                acc_q    <= '0;
                cnt_q    <= '0;
                neg_q    <= (mult_signed_a & rdat1[WORD_W-1]) ^ (mult_signed_b & rdat2[WORD_W-1]);
            end else if (state_q == StBusy) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CntW'(1);
            end
            // Bubbles carry all-zero fields so nothing downstream acts on them.
            if (!mem_stall) begin
                out_valid      <= lat_valid;
                out_result     <= lat_valid ? (mult ? mult_result : alu_result) : '0;
                out_wdata      <= lat_valid ? rdat2 : '0;
                out_rd         <= lat_valid ? rd : '0;
                out_dread      <= lat_valid & dread;
                out_dwrite     <= lat_valid ? dwrite : '0;
                out_reg_wr_src <= lat_valid ? reg_wr_src : '0;
                out_halt       <= lat_valid & halt;
                out_pc_plus4   <= lat_valid ? pc + WORD_W'(4) : '0;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, redirects, multiplier
// latency, flush/mem_stall/reset interaction.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, mem_stall;
    logic [31:0] pc, immediate, rdat1, rdat2;
    logic [3:0]  alu_op;
    logic        mult, mult_half, mult_signed_a, mult_signed_b;
    logic [4:0]  rd;
    logic        dread, halt, alu_src1, alu_src2, branch_pol;
    logic [1:0]  dwrite, reg_wr_src, pc_ctrl;
    logic        ex_stall, redirect, out_valid, out_dread, out_halt;
    logic [31:0] redirect_pc, out_result, out_wdata, out_pc_plus4;
    logic [4:0]  out_rd;
    logic [1:0]  out_dwrite, out_reg_wr_src;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .mem_stall(mem_stall),
        .pc(pc), .alu_op(alu_op), .mult(mult), .mult_half(mult_half),
        .mult_signed_a(mult_signed_a), .mult_signed_b(mult_signed_b), .rd(rd),
        .dread(dread), .dwrite(dwrite), .halt(halt), .immediate(immediate),
        .rdat1(rdat1), .rdat2(rdat2), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .reg_wr_src(reg_wr_src), .branch_pol(branch_pol), .pc_ctrl(pc_ctrl),
        .ex_stall(ex_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_result(out_result), .out_wdata(out_wdata),
        .out_rd(out_rd), .out_dread(out_dread), .out_dwrite(out_dwrite),
        .out_reg_wr_src(out_reg_wr_src), .out_halt(out_halt), .out_pc_plus4(out_pc_plus4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; flush = 0; mem_stall = 0; pc = 0; alu_op = 0; mult = 0;
        mult_half = 0; mult_signed_a = 0; mult_signed_b = 0; rd = 0; dread = 0;
        dwrite = 0; halt = 0; immediate = 0; rdat1 = 0; rdat2 = 0; alu_src1 = 0;
        alu_src2 = 0; reg_wr_src = 0; branch_pol = 0; pc_ctrl = 0;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        clear_inputs();
        in_valid = 1; alu_op = op; rdat1 = a; rdat2 = b;
        step();
        check(tag, out_result, exp);
    endtask

    task automatic set_mult(input logic half, input logic sa, input logic sb,
                            input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        in_valid = 1; mult = 1; mult_half = half; mult_signed_a = sa; mult_signed_b = sb;
        rdat1 = a; rdat2 = b; rd = 5'd9;
    endtask

    task automatic run_mult(input string tag, input logic half, input logic sa, input logic sb,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int stall_cnt;
        set_mult(half, sa, sb, a, b);
        #1;
        stall_cnt = 0;
        while (ex_stall && stall_cnt < 100) begin
            stall_cnt++;
            step();
        end
        check({tag, " stall_len"}, 64'(stall_cnt), 64'd33);
        check({tag, " bubble"}, 64'(out_valid), 64'd0);
        step();
        in_valid = 0; mult = 0;
        check({tag, " result"}, 64'(out_result), 64'(exp));
        check({tag, " valid"}, 64'(out_valid), 64'd1);
        check({tag, " rd"}, 64'(out_rd), 64'd9);
    endtask

    initial begin
        int seen;
        clear_inputs();
        rst = 1;
        step();
        step();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", 64'(out_result), 64'd0);
        check("rst out_pc_plus4", 64'(out_pc_plus4), 64'd0);
        check("rst ex_stall", 64'(ex_stall), 64'd0);
        rst = 0;

        // ADD overflow wraps, with passthrough fields
        clear_inputs();
        in_valid = 1; alu_op = 4'd0; rdat1 = 32'h7FFF_FFFF; rdat2 = 32'h1; pc = 32'h40;
        rd = 5'd3; dwrite = 2'd2; reg_wr_src = 2'd1; halt = 1;
        #1;
        check("add ex_stall", 64'(ex_stall), 64'd0);
        step();
        check("add result", 64'(out_result), 64'h8000_0000);
        check("add valid", 64'(out_valid), 64'd1);
        check("add rd", 64'(out_rd), 64'd3);
        check("add wdata", 64'(out_wdata), 64'h1);
        check("add dwrite", 64'(out_dwrite), 64'd2);
        check("add wr_src", 64'(out_reg_wr_src), 64'd1);
        check("add halt", 64'(out_halt), 64'd1);
        check("add pc_plus4", 64'(out_pc_plus4), 64'h44);

        alu_vec("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_vec("and", 4'd2, 32'hF0F0, 32'hFF00, 32'hF000);
        alu_vec("or", 4'd3, 32'hF0F0, 32'h0F0F, 32'hFFFF);
        alu_vec("xor", 4'd4, 32'hFF00, 32'h0FF0, 32'hF0F0);
        alu_vec("sll", 4'd5, 32'h1, 32'h3F, 32'h8000_0000);
        alu_vec("srl", 4'd6, 32'h8000_0000, 32'h4, 32'h0800_0000);
        alu_vec("sra", 4'd7, 32'h8000_0000, 32'h4, 32'hF800_0000);
        alu_vec("slt", 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1);
        alu_vec("sltu", 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0);

        // AUIPC-style operand selection
        clear_inputs();
        in_valid = 1; alu_src1 = 1; alu_src2 = 1; pc = 32'h1000; immediate = 32'h20;
        rdat1 = 32'h5555; rdat2 = 32'h7777;
        step();
        check("src pc+imm", 64'(out_result), 64'h1020);

        // BEQ taken / not taken, BNE, and mem_stall gating
        clear_inputs();
        in_valid = 1; alu_op = 4'd1; pc_ctrl = 2'd1; pc = 32'h100; immediate = 32'h20;
        rdat1 = 32'd5; rdat2 = 32'd5;
        #1;
        check("beq taken", 64'(redirect), 64'd1);
        check("beq target", 64'(redirect_pc), 64'h120);
        rdat2 = 32'd6;
        #1;
        check("beq not taken", 64'(redirect), 64'd0);
        branch_pol = 1;
        #1;
        check("bne taken", 64'(redirect), 64'd1);
        branch_pol = 0; rdat2 = 32'd5; mem_stall = 1;
        #1;
        check("beq mem_stall gate", 64'(redirect), 64'd0);
        mem_stall = 0; flush = 1;
        #1;
        check("beq flush gate", 64'(redirect), 64'd0);
        step();
        check("flush bubble", 64'(out_valid), 64'd0);

        // JAL and JALR
        clear_inputs();
        in_valid = 1; pc_ctrl = 2'd2; pc = 32'h300; immediate = 32'hFFFF_FFF0;
        #1;
        check("jal redirect", 64'(redirect), 64'd1);
        check("jal target", 64'(redirect_pc), 64'h2F0);
        pc_ctrl = 2'd3; pc = 32'h200; rdat1 = 32'h1003; immediate = 32'h4;
        #1;
        check("jalr redirect", 64'(redirect), 64'd1);
        check("jalr target", 64'(redirect_pc), 64'h1006);
        step();
        check("jalr pc_plus4", 64'(out_pc_plus4), 64'h204);

        // mem_stall holds a non-mult result
        alu_vec("pre-hold add", 4'd0, 32'd1, 32'd2, 32'd3);
        rdat1 = 32'd10; rdat2 = 32'd20; mem_stall = 1;
        #1;
        check("mem_stall ex_stall", 64'(ex_stall), 64'd1);
        step();
        check("mem_stall hold", 64'(out_result), 64'd3);
        mem_stall = 0;
        step();
        check("mem_stall release", 64'(out_result), 64'd30);

        run_mult("mulh", 1, 1, 1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF);
        run_mult("mul", 0, 1, 1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA);
        run_mult("mulhu", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mult("mulhsu", 1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Flush in the 10th BUSY cycle
        set_mult(1, 1, 1, 32'hFFFF_FFFE, 32'h3);
        for (int i = 0; i < 10; i++) step();
        flush = 1;
        step();
        clear_inputs();
        #1;
        check("flush ex_stall", 64'(ex_stall), 64'd0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("flush no result", 64'(seen), 64'd0);
        alu_vec("post-flush add", 4'd0, 32'd2, 32'd3, 32'd5);
        check("post-flush valid", 64'(out_valid), 64'd1);

        // mem_stall held 3 cycles during DONE
        set_mult(0, 1, 1, 32'hFFFF_FFFE, 32'h3);
        for (int i = 0; i < 33; i++) step();
        mem_stall = 1;
        #1;
        check("done stall ex_stall", 64'(ex_stall), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("done stall valid hold", 64'(out_valid), 64'd0);
            check("done stall result hold", 64'(out_result), 64'd0);
        end
        mem_stall = 0;
        #1;
        check("done release ex_stall", 64'(ex_stall), 64'd0);
        step();
        in_valid = 0; mult = 0;
        check("done release result", 64'(out_result), 64'hFFFF_FFFA);
        check("done release valid", 64'(out_valid), 64'd1);
        step();
        check("done latched once", 64'(out_valid), 64'd0);
        check("done back idle", 64'(ex_stall), 64'd0);

        // Reset mid-BUSY
        set_mult(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) step();
        rst = 1; in_valid = 0; mult = 0;
        step();
        check("rst busy out_valid", 64'(out_valid), 64'd0);
        check("rst busy out_result", 64'(out_result), 64'd0);
        check("rst busy out_rd", 64'(out_rd), 64'd0);
        check("rst busy ex_stall", 64'(ex_stall), 64'd0);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid || ex_stall) seen++;
        end
        check("rst busy no result", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline; consumes the decode→execute pipeline register contents and produces the execute→memory latch.
- Contains the ALU, branch/jump resolution and an iterative 32-cycle shift-add multiplier (M-extension MUL/MULH/MULHSU/MULHU).
- While a multiply is in flight, the block stalls the upstream pipeline.

Parameters:
- WORD_W, 32, datapath width
- MULT_CYCLES, 32, multiplier iteration count (must equal WORD_W)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  decode→execute latch holds a live instruction
- flush  in  1  kill the current instruction and any multiply in flight
- mem_stall  in  1  downstream memory stage not accepting
- pc  in  32  instruction PC
- alu_op  in  alu_op_t(4)  ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU
- mult, mult_half, mult_signed_a, mult_signed_b  in  1 each  multiplier control
- rd  in  5  destination register
- dread  in  1  load
- dwrite  in  2  store size
- halt  in  1  halt marker
- immediate, rdat1, rdat2  in  32 each  operands (already forwarded)
- alu_src1, alu_src2  in  1 each  0=rs1/1=PC; 0=rs2/1=imm
- reg_wr_src  in  2  writeback source
- branch_pol  in  1  0=take on zero, 1=take on nonzero
- pc_ctrl  in  2  0=inc, 1=branch, 2=JAL, 3=JALR
- ex_stall  out  1  hold decode→execute latch (en low)
- redirect  out  1  taken branch/jump; fetch redirects, younger stages flush
- redirect_pc  out  32  redirect target
- out_valid, out_result(32), out_wdata(32), out_rd(5), out_dread, out_dwrite(2), out_reg_wr_src(2), out_halt, out_pc_plus4(32)  out  registered execute→memory latch

Behaviour:
- Single clock `clk`. One clock; reset is synchronous and active-high (`rst`).
- On reset, all registered outputs are 0, the multiplier FSM is IDLE and ex_stall is 0.
- ALU:
  - opA = alu_src1 ? pc : rdat1; opB = alu_src2 ? immediate : rdat2.
  - Shift amount is opB[4:0]. SLT compares signed, SLTU unsigned; result is 0/1 zero-extended.
  - zero = (alu_result == 0).
- Redirect (combinational), gated by in_valid & ~flush & ~mem_stall:
  - pc_ctrl=1: redirect when zero ^ branch_pol; target = pc + immediate.
  - pc_ctrl=2: always redirect; target = pc + immediate.
  - pc_ctrl=3: always redirect; target = (rdat1 + immediate) & ~1.
  - Redirect is asserted exactly once per instruction.
- Multiplier FSM (IDLE, BUSY, DONE):
  - IDLE→BUSY: when in_valid & mult & ~flush. Latch |A| and |B|, where an operand is treated as signed only if its sign flag is set. Latch the result sign = signA^signB (signed operands only). Clear the 64-bit accumulator and the counter.
  - BUSY: one shift-add step per cycle; counter increments; →DONE when counter reaches MULT_CYCLES-1.
  - DONE: negate the product if the result sign is set; select low (mult_half=0) or high (mult_half=1) 32 bits. Present to the output latch; →IDLE when ~mem_stall.
  - ex_stall = (in_valid & mult & state==IDLE) | state==BUSY | (state==DONE & mem_stall), OR'd with mem_stall.
  - Latency: the multiply result is latched 33 cycles after acceptance, assuming no mem_stall.
- Output latch update rules, when ~mem_stall:
  - Non-mult instruction: latch the ALU result, rdat2 → out_wdata, and the control fields.
  - Mult instruction: latch only in DONE.
  - out_valid = in_valid & ~flush & (~mult | DONE).
  - While stalled in IDLE/BUSY with ~mem_stall: out_valid=0 (bubble).
  - When mem_stall: all outputs hold.
- flush has priority: the FSM returns to IDLE in the same cycle (abort mid-BUSY allowed); next out_valid=0; redirect=0.
- rst mid-BUSY: the FSM returns to IDLE and no result is produced.
- in_valid=0: no FSM start, no redirect, bubble latched.
- Overflow: all arithmetic wraps mod 2^32.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1 → out_result=0x80000000 one cycle later, out_valid=1, ex_stall=0.
- BEQ: rdat1=rdat2=5, pc=0x100, imm=0x20, branch_pol=0 → redirect=1, redirect_pc=0x120; same with rdat2=6 → redirect=0.
- JALR: rdat1=0x1003, imm=4 → redirect_pc=0x1006; out_pc_plus4 = pc+4.
- MULH signed: 0xFFFFFFFE × 0x00000003 → ex_stall high for exactly 33 cycles; out_result=0xFFFFFFFF; MUL low half gives 0xFFFFFFFA. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → high half 0xFFFFFFFE.
- flush asserted in BUSY cycle 10 → ex_stall drops next cycle, out_valid stays 0, the next ADD completes normally.
- mem_stall held 3 cycles during DONE → outputs held constant, result latched once after release; rst during BUSY → all outputs 0, FSM IDLE.
